// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM port arbiter slice.
// Port indices, address width and arbiter FSM encoding.
package psram_pkg;

  localparam int PSRAM_ADDR_W = 22;

  localparam logic [1:0] PORT_CART = 2'd0;
  localparam logic [1:0] PORT_LOAD = 2'd1;
  localparam logic [1:0] PORT_DBG  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_END,
    COMPLETE
  } psram_st_e;

endpackage

// File: rtl/psram_prio_rr_pick.sv
// Winner selection: cart port first unless its streak is spent,
// then round-robin between loader and debug ports.
module psram_prio_rr_pick
  import psram_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic       i_streak_full,
  input  logic       i_rr_last,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic w_low;

  assign w_low   = i_req[PORT_LOAD] | i_req[PORT_DBG];
  assign o_valid = |i_req;

  // i_rr_last: 0 = loader granted last, 1 = debug granted last
  always_comb begin
    o_idx = PORT_CART;
    if (i_req[PORT_CART] && !(i_streak_full && w_low))
      o_idx = PORT_CART;
    else if (i_req[PORT_LOAD] && i_req[PORT_DBG])
      o_idx = i_rr_last ? PORT_LOAD : PORT_DBG;
    else if (i_req[PORT_LOAD])
      o_idx = PORT_LOAD;
    else if (i_req[PORT_DBG])
      o_idx = PORT_DBG;
  end

endmodule

// File: rtl/psram_port_arbiter.sv
// Three-port arbiter in front of the PSRAM byte controller:
// one byte transaction at a time, with busy timeouts.
module psram_port_arbiter
  import psram_pkg::*;
#(
  parameter int ADDR_W        = PSRAM_ADDR_W,
  parameter int MAX_P0_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            p_req,
  input  logic [2:0]            p_we,
  input  logic [3*ADDR_W-1:0]   p_addr,
  input  logic [23:0]           p_wdata,
  output logic [2:0]            p_ack,
  output logic                  p_err,
  output logic [7:0]            p_rdata,
  output logic                  ds_read_req,
  output logic                  ds_write_req,
  output logic [ADDR_W-1:0]     ds_address,
  output logic [7:0]            ds_write_data,
  input  logic [7:0]            ds_read_data,
  input  logic                  ds_data_valid,
  input  logic                  ds_busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(MAX_P0_STREAK + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_P0_STREAK);

  psram_st_e r_state, w_next;

  logic [1:0]        r_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [TW-1:0]     r_tmr;
  logic [SW-1:0]     r_streak;
  logic              r_rr_last;
  logic              r_seen;
  logic              r_err;
  logic              r_rd_req;
  logic              r_wr_req;
  logic [7:0]        r_rdata;

  logic [1:0] w_pick;
  logic       w_pick_vld;
  logic       w_low;
  logic       w_tmo;
  logic       w_streak_full;
  logic       w_grant;
  logic       w_issue;
  logic       w_tmr_clr;
  logic       w_seen_clr;
  logic       w_set_err;
  logic       w_capture;

  assign w_low         = p_req[PORT_LOAD] | p_req[PORT_DBG];
  assign w_tmo         = (r_tmr == TMO_LAST);
  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_capture     = (r_state == WAIT_END) && ds_data_valid;

  assign ds_read_req   = r_rd_req;
  assign ds_write_req  = r_wr_req;
  assign ds_address    = r_addr;
  assign ds_write_data = r_wdata;
  assign p_rdata       = r_rdata;

  psram_prio_rr_pick u_pick (
    .i_req         (p_req),
    .i_streak_full (w_streak_full),
    .i_rr_last     (r_rr_last),
    .o_idx         (w_pick),
    .o_valid       (w_pick_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_issue    = 1'b0;
    w_tmr_clr  = 1'b0;
    w_seen_clr = 1'b0;
    w_set_err  = 1'b0;
    p_ack      = 3'b000;
    p_err      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_grant = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (!ds_busy) begin
          w_issue   = 1'b1;
          w_tmr_clr = 1'b1;
          w_next    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (ds_busy) begin
          w_tmr_clr  = 1'b1;
          w_seen_clr = 1'b1;
          w_next     = WAIT_END;
        end else if (w_tmo) begin
          w_set_err = 1'b1;
          w_next    = COMPLETE;
        end
      end
      WAIT_END: begin
        // a data_valid on the falling-busy cycle still counts
        if (!ds_busy) begin
          w_set_err = !r_we && !(r_seen || ds_data_valid);
          w_next    = COMPLETE;
        end else if (w_tmo) begin
          w_set_err = 1'b1;
          w_next    = COMPLETE;
        end
      end
      COMPLETE: begin
        p_ack  = 3'(3'b001 << r_idx);
        p_err  = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tmr     <= '0;
      r_streak  <= '0;
      r_rr_last <= 1'b0;
      r_seen    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_req  <= 1'b0;
      r_wr_req  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_req <= w_issue & ~r_we;
      r_wr_req <= w_issue & r_we;
      if (w_grant) begin
        r_idx   <= w_pick;
        r_we    <= p_we[w_pick];
        r_addr  <= p_addr[w_pick*ADDR_W +: ADDR_W];
        r_wdata <= p_wdata[w_pick*8 +: 8];
        if (w_pick == PORT_CART) begin
          if (!w_low)
            r_streak <= '0;
          else if (!w_streak_full)
            r_streak <= r_streak + 1'b1;
        end else begin
          r_streak  <= '0;
          r_rr_last <= (w_pick == PORT_DBG);
        end
      end
      if (w_tmr_clr)
        r_tmr <= '0;
      else if (r_state inside {WAIT_START, WAIT_END})
        r_tmr <= r_tmr + 1'b1;
      if (w_seen_clr)
        r_seen <= 1'b0;
      else if (w_capture)
        r_seen <= 1'b1;
      if (w_capture)
        r_rdata <= ds_read_data;
      if (w_set_err)
        r_err <= 1'b1;
      else if (r_state == COMPLETE)
        r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Randomised bench for psram_port_arbiter with a transaction-level
// arbitration/completion model and a scripted controller model.
module tb_psram_port_arbiter;

  localparam int AW  = 22;
  localparam int MAXS = 4;
  localparam int TMO = 64;

  logic          clk;
  logic          reset_n;
  logic [2:0]    p_req;
  logic [2:0]    p_we;
  logic [3*AW-1:0] p_addr;
  logic [23:0]   p_wdata;
  logic [2:0]    p_ack;
  logic          p_err;
  logic [7:0]    p_rdata;
  logic          ds_read_req;
  logic          ds_write_req;
  logic [AW-1:0] ds_address;
  logic [7:0]    ds_write_data;
  logic [7:0]    ds_read_data;
  logic          ds_data_valid;
  logic          ds_busy;
  logic          ctl_busy;
  logic          hold_busy;

  assign ds_busy = ctl_busy | hold_busy;

  psram_port_arbiter #(
    .ADDR_W(AW), .MAX_P0_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(p_ack), .p_err(p_err), .p_rdata(p_rdata),
    .ds_read_req(ds_read_req), .ds_write_req(ds_write_req),
    .ds_address(ds_address), .ds_write_data(ds_write_data),
    .ds_read_data(ds_read_data), .ds_data_valid(ds_data_valid),
    .ds_busy(ds_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // model state
  int          m_streak;
  bit          m_last2;
  logic [7:0]  m_rdata;
  int          exp_port = -1;
  bit          exp_we;
  bit          exp_err;
  int          exp_mode;
  logic [AW-1:0] exp_addr;
  logic [7:0]  exp_wdata;

  // controller script: 0 normal, 1 never busy, 2 busy without data
  int          cur_mode, cur_d1, cur_d2, cur_vpos;
  logic [7:0]  cur_data;

  // observations
  int          cyc = 0;
  int          n_pulse;
  int          pulse_cyc;
  bit          got_ack;
  logic [2:0]  last_ack;
  logic        last_err;
  logic [7:0]  last_rdata;
  int          last_lat;
  logic [AW-1:0] pulse_addr;
  logic [7:0]  pulse_wdata;
  logic        pulse_wr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int ack_port(input logic [2:0] a);
    case (a)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int model_pick();
    bit low;
    low = p_req[1] | p_req[2];
    if (p_req[0] && !(m_streak >= MAXS && low)) return 0;
    if (p_req[1] && p_req[2]) return m_last2 ? 1 : 2;
    return p_req[1] ? 1 : 2;
  endfunction

  // scripted downstream controller
  initial begin
    bit rd;
    ctl_busy = 1'b0;
    ds_data_valid = 1'b0;
    ds_read_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n && (ds_read_req || ds_write_req)) begin
        rd = ds_read_req;
        if (cur_mode != 1) begin
          repeat (cur_d1) @(negedge clk);
          for (int k = 0; k <= cur_d2; k++) begin
            if (k > 0) @(negedge clk);
            ctl_busy = (k < cur_d2);
            if (rd && cur_mode == 0 && k == cur_vpos) begin
              ds_data_valid = 1'b1;
              ds_read_data = cur_data;
              m_rdata = cur_data;
            end else begin
              ds_data_valid = 1'b0;
            end
          end
          @(negedge clk);
          ds_data_valid = 1'b0;
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [2:0] eack;
    cyc++;
    if (reset_n) begin
      if (ds_read_req && ds_write_req)
        chk("req_exclusive", 32'(ds_write_req), 32'(0));
      if (ds_read_req || ds_write_req) begin
        n_pulse++;
        pulse_cyc = cyc;
        pulse_addr = ds_address;
        pulse_wdata = ds_write_data;
        pulse_wr = ds_write_req;
        if (exp_port < 0)
          chk("pulse_spurious", 32'(1), 32'(0));
        chk("pulse_kind", 32'(ds_write_req), 32'(exp_we));
        chk("pulse_addr", 32'(ds_address), 32'(exp_addr));
        chk("pulse_wdata", 32'(ds_write_data), 32'(exp_wdata));
      end
      if (exp_port >= 0 && n_pulse > 0)
        chk("addr_hold", 32'(ds_address), 32'(exp_addr));
      if (p_ack != 3'b000) begin
        eack = (exp_port >= 0) ? 3'(3'b001 << exp_port) : 3'b000;
        chk("ack_vec", 32'(p_ack), 32'(eack));
        chk("ack_err", 32'(p_err), 32'(exp_err));
        if (!exp_we)
          chk("ack_rdata", 32'(p_rdata), 32'(m_rdata));
        chk("one_pulse", 32'(n_pulse), 32'(1));
        if (exp_mode == 1)
          chk("tmo_latency", 32'(cyc - pulse_cyc), 32'(TMO));
        last_ack = p_ack;
        last_err = p_err;
        last_rdata = p_rdata;
        last_lat = cyc - pulse_cyc;
        got_ack = 1'b1;
      end
    end
  end

  task automatic set_req(input int p, input bit we,
                         input logic [AW-1:0] a, input logic [7:0] d);
    p_req[p] = 1'b1;
    p_we[p] = we;
    p_addr[p*AW +: AW] = a;
    p_wdata[p*8 +: 8] = d;
  endtask

  task automatic finish_up();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic arb_begin(output int w);
    bit low;
    low = p_req[1] | p_req[2];
    w = model_pick();
    exp_we = p_we[w];
    exp_addr = p_addr[w*AW +: AW];
    exp_wdata = p_wdata[w*8 +: 8];
    exp_mode = cur_mode;
    exp_err = (cur_mode == 1) || (cur_mode == 2 && !p_we[w]);
    n_pulse = 0;
    got_ack = 1'b0;
    if (w == 0) begin
      m_streak = low ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
    end else begin
      m_streak = 0;
      m_last2 = (w == 2);
    end
    exp_port = w;
  endtask

  task automatic arb_wait(input int w);
    int n;
    n = 0;
    while (!got_ack && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!got_ack) begin
      chk("ack_timeout", 32'(0), 32'(1));
      finish_up();
    end
    exp_port = -1;
    p_req[w] = 1'b0;
  endtask

  task automatic arb_step(output int w);
    arb_begin(w);
    arb_wait(w);
  endtask

  task automatic do_reset();
    exp_port = -1;
    p_req = 3'b000;
    hold_busy = 1'b0;
    reset_n = 1'b0;
    repeat (40) @(negedge clk);
    m_streak = 0;
    m_last2 = 1'b0;
    m_rdata = 8'h00;
    #1 reset_n = 1'b1;
  endtask

  task automatic drain();
    int w;
    while (p_req != 3'b000) arb_step(w);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 32'(p_ack), 32'(0));
    chk({tag, "_err"}, 32'(p_err), 32'(0));
    chk({tag, "_rdata"}, 32'(p_rdata), 32'(0));
    chk({tag, "_rdreq"}, 32'(ds_read_req), 32'(0));
    chk({tag, "_wrreq"}, 32'(ds_write_req), 32'(0));
    chk({tag, "_addr"}, 32'(ds_address), 32'(0));
    chk({tag, "_wdata"}, 32'(ds_write_data), 32'(0));
  endtask

  initial begin
    int w;
    int seq[$];
    int exp3[6];
    int exp4[4];
    int r;
    int n;

    exp3 = '{0, 0, 0, 0, 2, 0};
    exp4 = '{2, 1, 2, 1};
    reset_n = 1'b0;
    p_req = '0;
    p_we = '0;
    p_addr = '0;
    p_wdata = '0;
    hold_busy = 1'b0;
    m_streak = 0;
    m_last2 = 1'b0;
    m_rdata = 8'h00;
    cur_mode = 0; cur_d1 = 0; cur_d2 = 1; cur_vpos = 1; cur_data = 8'h00;
    @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    #1 reset_n = 1'b1;

    // loader write
    set_req(1, 1'b1, 22'h12345, 8'hA5);
    cur_mode = 0; cur_d1 = 2; cur_d2 = 4; cur_vpos = 1;
    arb_step(w);
    chk("t1_ack", 32'(last_ack), 32'(3'b010));
    chk("t1_err", 32'(last_err), 32'(0));
    chk("t1_wr", 32'(pulse_wr), 32'(1));
    chk("t1_addr", 32'(pulse_addr), 32'(22'h12345));
    chk("t1_wdata", 32'(pulse_wdata), 32'(8'hA5));

    // cart read, controller busy before issue, same-cycle data
    hold_busy = 1'b1;
    set_req(0, 1'b0, 22'h00100, 8'h00);
    cur_mode = 0; cur_d1 = 0; cur_d2 = 3; cur_vpos = 3; cur_data = 8'h5C;
    fork
      begin
        repeat (10) @(negedge clk);
        #2 chk("t2_hold_no_pulse", 32'(n_pulse), 32'(0));
        hold_busy = 1'b0;
      end
    join_none
    arb_step(w);
    chk("t2_ack", 32'(last_ack), 32'(3'b001));
    chk("t2_rdata", 32'(last_rdata), 32'(8'h5C));
    chk("t2_err", 32'(last_err), 32'(0));

    // cart streak against a waiting debug port
    set_req(2, 1'b0, 22'h2AAAA, 8'h00);
    cur_mode = 0; cur_d1 = 0; cur_d2 = 1; cur_vpos = 1;
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b0, 22'($urandom), 8'h00);
      cur_data = 8'($urandom);
      arb_step(w);
      chk("t3_order", 32'(ack_port(last_ack)), 32'(exp3[i]));
    end
    drain();

    // timeout: no busy, then busy without read data
    set_req(2, 1'b0, 22'h00777, 8'h00);
    cur_mode = 1;
    arb_step(w);
    chk("t5_ack", 32'(last_ack), 32'(3'b100));
    chk("t5_err", 32'(last_err), 32'(1));
    chk("t5_lat", 32'(last_lat), 32'(64));
    set_req(1, 1'b0, 22'h00888, 8'h00);
    cur_mode = 2; cur_d1 = 1; cur_d2 = 5;
    arb_step(w);
    chk("t5b_err", 32'(last_err), 32'(1));

    // loader/debug alternation from reset
    do_reset();
    cur_mode = 0; cur_d1 = 0; cur_d2 = 2; cur_vpos = 1;
    set_req(1, 1'b1, 22'h00010, 8'h11);
    set_req(2, 1'b1, 22'h00020, 8'h22);
    for (int i = 0; i < 4; i++) begin
      arb_step(w);
      chk("t4_order", 32'(ack_port(last_ack)), 32'(exp4[i]));
      set_req(w, 1'b1, 22'($urandom), 8'($urandom));
    end
    drain();

    // randomised traffic
    for (int it = 0; it < 120; it++) begin
      for (int p = 0; p < 3; p++)
        if (!p_req[p] && $urandom_range(0, 2) != 0)
          set_req(p, 1'($urandom_range(0, 1)), 22'($urandom), 8'($urandom));
      if (p_req == 3'b000)
        set_req($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                22'($urandom), 8'($urandom));
      r = $urandom_range(0, 99);
      cur_mode = (r < 70) ? 0 : ((r < 85) ? 1 : 2);
      cur_d1 = $urandom_range(0, 5);
      cur_d2 = $urandom_range(1, 8);
      cur_vpos = $urandom_range(1, cur_d2);
      cur_data = 8'($urandom);
      arb_step(w);
    end
    drain();

    // reset while waiting for busy to fall
    set_req(0, 1'b0, 22'h00200, 8'h00);
    cur_mode = 2; cur_d1 = 0; cur_d2 = 30; cur_vpos = 1;
    arb_begin(w);
    n = 0;
    while (!ds_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_busy_seen", 32'(ds_busy), 32'(1));
    repeat (3) @(negedge clk);
    #1;
    exp_port = -1;
    p_req = 3'b000;
    reset_n = 1'b0;
    #1 check_zero("midrst");
    repeat (40) @(negedge clk);
    m_streak = 0;
    m_last2 = 1'b0;
    m_rdata = 8'h00;
    #1 reset_n = 1'b1;
    set_req(0, 1'b0, 22'h3FFFFF, 8'h00);
    cur_mode = 0; cur_d1 = 1; cur_d2 = 2; cur_vpos = 1; cur_data = 8'h3C;
    arb_step(w);
    chk("post_rst_ack", 32'(last_ack), 32'(3'b001));
    chk("post_rst_rdata", 32'(last_rdata), 32'(8'h3C));
    chk("post_rst_err", 32'(last_err), 32'(0));
    repeat (5) @(negedge clk);
    finish_up();
  end

endmodule

// File: doc/psram_port_arbiter.md
Name: psram_port_arbiter

Overview:
Shares the single PSRAM byte-access controller between three requesters. Port 0 is the 7800 cartridge-bus read path and has latency priority. Port 1 is the ROM loader (writes). Port 2 is the debug/readback path. The block sits between the requesters and psram_byte_controller. It serialises one byte transaction at a time, sequences the controller's req/busy/data_valid handshake, and returns per-port completion with a timeout error.

Parameters:
ADDR_W, 22, byte address width (4 MB PSRAM)
MAX_P0_STREAK, 4, consecutive port-0 grants allowed while port 1 or 2 waits
TIMEOUT, 64, cycles allowed for ds_busy to rise after issue, and separately for it to fall

Ports:
clk  in  1  system clock (81 MHz)
reset_n  in  1  async active-low reset
p_req  in  3  per-port request; held high, with fields stable, until p_ack
p_we  in  3  per-port 1=write, 0=read
p_addr  in  3*ADDR_W  packed addresses; port n at [n*ADDR_W +: ADDR_W]
p_wdata  in  24  packed write bytes; port n at [n*8 +: 8]
p_ack  out  3  one-cycle completion pulse for the granted port
p_err  out  1  valid with p_ack; 1 = timeout or missing read data
p_rdata  out  8  read byte; valid with p_ack when the port's p_we=0
ds_read_req  out  1  to controller, one-cycle pulse
ds_write_req  out  1  to controller, one-cycle pulse
ds_address  out  ADDR_W  to controller
ds_write_data  out  8  to controller
ds_read_data  in  8  from controller
ds_data_valid  in  1  from controller
ds_busy  in  1  from controller

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, streak=0, rr_last=0 (port 1 considered last, so port 2 wins the first tie).
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_END, COMPLETE.
- IDLE, arbitration when any p_req is high:
  - Port 0 wins unless streak==MAX_P0_STREAK and port 1 or 2 is requesting.
  - Between ports 1 and 2: if both request, grant the one not equal to rr_last; otherwise grant whichever requests.
  - On grant: latch port index, we, addr, wdata into registers; go to ISSUE.
- Streak counter:
  - +1 on each port-0 grant while port 1 or 2 is requesting, saturating at MAX_P0_STREAK.
  - Cleared on any port-1/2 grant, and on a port-0 grant with no low-port request.
  - rr_last is updated on each port-1/2 grant.
- ISSUE:
  - If ds_busy==0: pulse ds_write_req (we=1) or ds_read_req (we=0) for exactly one cycle; zero timer; go to WAIT_START.
  - Otherwise hold in ISSUE. No timer runs in ISSUE.
  - ds_read_req and ds_write_req are never high together.
- ds_address and ds_write_data are driven from the latched registers and are stable from ISSUE through COMPLETE.
- WAIT_START:
  - ds_busy==1 -> zero timer, clear the rdata-seen flag, go to WAIT_END.
  - Timer reaches TIMEOUT-1 -> set err, go to COMPLETE.
- WAIT_END:
  - Any cycle with ds_data_valid==1 captures ds_read_data into p_rdata and sets the seen flag.
  - ds_busy==0 -> go to COMPLETE. err is set if this is a read and no rdata was seen. A same-cycle ds_data_valid is still captured.
  - Timer reaches TIMEOUT-1 -> err=1, go to COMPLETE.
- COMPLETE: p_ack[idx]=1 for one cycle with p_err; clear err; go to IDLE.
- Requester is free to change fields or drop p_req the cycle after p_ack. A still-high p_req re-arbitrates in IDLE.
- p_rdata holds its last value between acks. For writes, p_rdata content is don't-care.
- Dropping p_req mid-transaction has no effect; the transaction completes and acks.
- One transaction is outstanding at a time. Minimum issue-to-ack latency is controller latency + 3 cycles; there is one IDLE cycle between transactions.
- Reset mid-transaction: immediate return to IDLE, no ack. The downstream controller shares reset_n.

Decomposition:
- Shared package psram_pkg holds:
  - PSRAM_ADDR_W=22.
  - Port indices PORT_CART=0, PORT_LOAD=1, PORT_DBG=2.
  - FSM state encoding.
- One natural sub-module, psram_prio_rr_pick: combinational winner selection from p_req, streak-limit flag and rr_last; outputs a 2-bit index and a valid.

Test Plan:
- Single port-1 write to addr 0x12345 with data 0xA5 -> exactly one ds_write_req pulse; ds_address=0x12345 and ds_write_data=0xA5 held through completion; p_ack=3'b010, p_err=0.
- Port-0 read of 0x00100, model returns 0x5C -> one ds_read_req pulse; p_ack=3'b001, p_rdata=0x5C, p_err=0.
- Port 0 requesting continuously while port 2 waits, MAX_P0_STREAK=4 -> grant order 0,0,0,0,2,0,…; port 2 is never starved.
- Ports 1 and 2 both requesting, port 0 idle -> grants alternate 2,1,2,1 starting from reset.
- Model never raises ds_busy, TIMEOUT=64 -> p_ack for the granted port 64 cycles after issue with p_err=1. Separately, busy pulses but ds_data_valid never asserts on a read -> p_err=1.
- reset_n asserted during WAIT_END -> all outputs 0 asynchronously and no p_ack. After release a new port-0 read completes normally.
